// File: rtl/bsram_be_clr_if.sv
// Request/response bundle for bsram_be_clr: read port, byte-enabled write port,
// clear request and array-ready status.
interface bsram_be_clr_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  logic                  readEnable;
  logic [ADDR_WIDTH-1:0] readAddress;
  logic [DATA_WIDTH-1:0] readData;
  logic                  readValid;
  logic                  writeEnable;
  logic [NUM_BYTES-1:0]  writeByteEnable;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  clearRequest;
  logic                  ready;

  modport master (
    output readEnable, readAddress, writeEnable, writeByteEnable, writeAddress, writeData,
    output clearRequest,
    input  readData, readValid, ready
  );

  modport slave (
    input  readEnable, readAddress, writeEnable, writeByteEnable, writeAddress, writeData,
    input  clearRequest,
    output readData, readValid, ready
  );
endinterface

// File: rtl/bsram_be_clr.sv
// Single-write/single-read SRAM with byte enables, 0/1-cycle read latency, write-to-read
// forwarding and a hardware clear engine that zeroes the array after reset or on request.
module bsram_be_clr #(
  parameter int unsigned CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          report,
  bsram_be_clr_if.slave bus
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % 8 != 0) || (READ_LATENCY > 1)) begin : g_bad_params
    $fatal(1, "bsram_be_clr: DATA_WIDTH must be a multiple of 8 and READ_LATENCY 0 or 1");
  end

  typedef enum logic {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
  logic [31:0]           cycles_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] merged;
  logic                  accepted;
  logic                  rd_fire;
  logic                  wr_fire;

  assign bus.ready = (state_q == StReady);
  // A clear request in READY pre-empts any access issued in the same cycle.
  assign accepted  = bus.ready & ~bus.clearRequest;
  assign rd_fire   = accepted & bus.readEnable;
  assign wr_fire   = accepted & bus.writeEnable;

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    unique case (state_q)
      StClear: begin
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (bus.clearRequest) begin
          state_d     = StClear;
          clear_ptr_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StClear;
      clear_ptr_q <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      cycles_q    <= cycles_q + 32'd1;
    end
  end

  // Array itself has no reset; the clear engine is what zeroes it.
  always_ff @(posedge clock) begin
    if (state_q == StClear) begin
      mem_q[clear_ptr_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.writeByteEnable[i]) begin
          mem_q[bus.writeAddress][8*i +: 8] <= bus.writeData[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    merged = mem_q[bus.readAddress];
    if (bus.writeEnable && bus.readEnable && (bus.readAddress == bus.writeAddress)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.writeByteEnable[i]) begin
          merged[8*i +: 8] = bus.writeData[8*i +: 8];
        end
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_read
    assign bus.readValid = rd_fire;
    assign bus.readData  = rd_fire ? merged : '0;
  end else begin : g_reg_read
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rvalid_d = rd_fire;
      rdata_d  = rd_fire ? merged : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rvalid_d;
        rdata_q  <= rdata_d;
      end
    end

    assign bus.readValid = rvalid_q;
    assign bus.readData  = rdata_q;
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report) begin
      $display("core %0d cycle %0d state %s ptr %0d | rd en %b addr %h data %h valid %b | wr en %b be %b addr %h data %h",
               CORE, cycles_q, (state_q == StReady) ? "READY" : "CLEAR", clear_ptr_q,
               bus.readEnable, bus.readAddress, bus.readData, bus.readValid,
               bus.writeEnable, bus.writeByteEnable, bus.writeAddress, bus.writeData);
    end
  end
`endif
endmodule

// File: doc/bsram_be_clr.md
Name: bsram_be_clr

Overview:
- Parametrised successor to the single-cycle core BSRAM.
- Single-write/single-read synchronous SRAM with per-byte write enables, selectable read latency (0 or 1 cycle) and same-address write-to-read forwarding with byte merge.
- Hardware clear engine zeroes the whole array after reset and on request, with `ready` reporting array availability.
- Used as instruction/data scratchpad and register-file backing store in BRISC-V cores.

Parameters:
- CORE  0  core index printed in report output
- DATA_WIDTH  32  word width in bits; must be a multiple of 8
- ADDR_WIDTH  8  address bits; MEM_DEPTH = 1 << ADDR_WIDTH
- READ_LATENCY  0  0 = combinational read, 1 = registered read
- NUM_BYTES  DATA_WIDTH/8  derived localparam, not overridable

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- readEnable  in  1  read request
- readAddress  in  ADDR_WIDTH  read word address
- readData  out  DATA_WIDTH  read data
- readValid  out  1  readData holds a valid read result
- writeEnable  in  1  write request
- writeByteEnable  in  NUM_BYTES  bit i enables writeData[8i+7:8i]
- writeAddress  in  ADDR_WIDTH  write word address
- writeData  in  DATA_WIDTH  write data
- clearRequest  in  1  single-cycle pulse starts a full-array clear
- ready  out  1  1 = array accepts reads and writes
- report  in  1  print per-cycle status via $display

Behaviour:
- State machine has two states, CLEAR and READY. clearPtr is an ADDR_WIDTH counter.
- While reset = 0 (async): state = CLEAR, clearPtr = 0, ready = 0, readValid = 0, registered readData = 0, cycles = 0. Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to sram[clearPtr]; clearPtr increments.
  - When clearPtr == MEM_DEPTH-1 is written, next state = READY.
  - Clear therefore takes exactly MEM_DEPTH cycles; ready = 1 from the MEM_DEPTH-th posedge after reset release.
  - Read/write requests are ignored: no array update, readValid = 0, readData = 0.
  - clearRequest is ignored.
  - Reset asserted mid-clear restarts the clear from address 0.
- READY state:
  - ready = 1.
  - clearRequest = 1: next state = CLEAR, clearPtr = 0, and ready = 0 from the next cycle. Any read/write in that same cycle is dropped.
- Request acceptance: accepted = ready & ~clearRequest.
- Write: on posedge, if accepted & writeEnable, for each i with writeByteEnable[i] = 1, sram[writeAddress][8i+7:8i] <= writeData[8i+7:8i]. Unselected bytes are unchanged. writeByteEnable = 0 is a no-op.
- Merged read value m:
  - If writeEnable & readEnable & (readAddress == writeAddress), each byte i is writeData byte i when writeByteEnable[i] = 1, else sram byte i.
  - Otherwise m = sram[readAddress].
- READ_LATENCY = 0:
  - readData = m when accepted & readEnable, else 0, combinationally.
  - readValid = accepted & readEnable, combinationally.
- READ_LATENCY = 1:
  - On posedge, readValid <= accepted & readEnable.
  - On posedge, readData <= m when accepted & readEnable, else 0.
  - The captured value reflects the same-cycle write (forwarded); readData is 0 whenever readValid is 0.
- Invariant: readData == 0 whenever readValid == 0, in both modes.
- Illegal parameters: DATA_WIDTH % 8 != 0 or READ_LATENCY not in {0,1} → $display an error and $finish at time 0.
- cycles: 32-bit counter, +1 per posedge, 0 during reset.
- Report: when report = 1 at posedge, $display core, cycle, state, clearPtr, readEnable/readAddress/readData/readValid and writeEnable/writeByteEnable/writeAddress/writeData.

Test Plan:
- Reset clear (DATA_WIDTH=32, ADDR_WIDTH=4, READ_LATENCY=0): preload all 16 words to 0xFFFFFFFF via backdoor, release reset → ready = 0 for 16 cycles, then 1; read of every address returns 0x00000000 with readValid = 1.
- Byte enable: write 0xAABBCCDD to addr 3 with BE = 4'b1111, then 0x11223344 with BE = 4'b0101 → read addr 3 returns 0xAA22CC44.
- Forwarding, READ_LATENCY=0 and 1: addr 5 holds 0x12345678; same cycle write 0xDEADBEEF with BE = 4'b1100 and read addr 5 → readData = 0xDEAD5678 (combinationally for latency 0, next cycle for latency 1); readValid = 1 in the matching cycle.
- Latency 1 idle: read addr 2 (holds 0x0000CAFE), then readEnable = 0 → readData = 0x0000CAFE with readValid = 1 for one cycle, then 0x00000000 with readValid = 0.
- clearRequest with same-cycle write of 0x55 to addr 7 → write dropped; ready = 0 for 16 cycles; afterwards addr 7 reads 0x00000000. A second clearRequest pulse during the clear has no effect (still 16 cycles total).
- Reset mid-clear: assert reset at clear cycle 8 for 2 cycles, release → clear restarts and ready rises 16 cycles after the release; requests made during the clear produce readValid = 0 and no array change.
